// File: rtl/uart_pkg.sv
// Shared UART constants: frame format, default sizing and RX state encoding.
package uart_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_OS_RATE    = 16;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_deser_if.sv
// AXI-Stream byte channel carrying received UART data.
interface uart_rx_deser_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for an asynchronous serial line; resets to the idle level.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic rx_in,
    output logic rxs
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: oversampled start validation, LSB-first deserialiser,
// single-entry AXI-Stream holding register with framing-error and overrun pulses.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned OS_RATE     = DEF_OS_RATE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               rx_in,
    input  logic               os_en,
    uart_rx_deser_if.master    m_axis,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned OS_W  = $clog2(OS_RATE);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic                  rxs;
    logic [2:0]            state_q, state_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;
    logic                  byte_done;
    logic                  frame_bad;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .rx_in (rx_in),
        .rxs   (rxs)
    );

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (os_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rxs == START_BIT) begin
                        state_d  = ST_START;
                        os_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (os_cnt_q == OS_MID) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        // A start bit gone high by mid-bit was line noise.
                        state_d   = (rxs == START_BIT) ? ST_DATA : ST_IDLE;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                ST_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        shift_d   = {rxs, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                ST_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        if (rxs == STOP_BIT) begin
                            byte_done = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = ST_BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line returns idle so a break is not decoded as frames.
                    if (rxs == IDLE_LEVEL) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_bad;
            overrun_q   <= byte_done && valid_q && !m_axis.ready;
            // A handshake in the completion cycle frees the register for the new byte.
            if (byte_done && (!valid_q || m_axis.ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && m_axis.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_axis.data  = data_q;
    assign m_axis.valid = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule
